// File: rtl/multi_cycle_control.sv
// Control FSM for the multi-cycle MIPS-subset CPU: sequences IF/ID/EXE/MEM/WB and decodes
// every datapath control from (state, op). Define HALT_EN to add the HALT state for op 111111.
module multi_cycle_control #(
  parameter int unsigned MEM_TMO = 15,
  parameter int unsigned OPW     = 6
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic [OPW-1:0] op,
  input  logic           zero,
  input  logic           mem_ready,
  output logic [2:0]     state,
  output logic           PCWre,
  output logic           IRWre,
  output logic           RegWre,
  output logic           mRD,
  output logic           mWR,
  output logic           ALUSrcB,
  output logic           ExtSel,
  output logic [1:0]     RegDst,
  output logic           DBDataSrc,
  output logic [1:0]     PCSrc,
  output logic [2:0]     ALUOp,
  output logic           mem_err,
  output logic           halted
);

  localparam logic [OPW-1:0] OpAdd  = OPW'(6'b000000);
  localparam logic [OPW-1:0] OpSub  = OPW'(6'b000001);
  localparam logic [OPW-1:0] OpAndi = OPW'(6'b010000);
  localparam logic [OPW-1:0] OpOri  = OPW'(6'b010010);
  localparam logic [OPW-1:0] OpSlt  = OPW'(6'b100111);
  localparam logic [OPW-1:0] OpSw   = OPW'(6'b110000);
  localparam logic [OPW-1:0] OpLw   = OPW'(6'b110001);
  localparam logic [OPW-1:0] OpBeq  = OPW'(6'b110100);
  localparam logic [OPW-1:0] OpBne  = OPW'(6'b110101);
  localparam logic [OPW-1:0] OpJ    = OPW'(6'b111000);
  localparam logic [OPW-1:0] OpJal  = OPW'(6'b111010);
  localparam logic [7:0]     TmoLast = 8'(MEM_TMO - 1);

  // HALT needs a ninth encoding, so the register widens by one bit; state shows the low 3 bits.
`ifdef HALT_EN
  localparam logic [OPW-1:0] OpHalt = OPW'(6'b111111);
  typedef enum logic [3:0] {
    StIf = 4'b0000, StId = 4'b0001, StExeLs = 4'b0010, StMem = 4'b0011, StWbLd = 4'b0100,
    StExeBr = 4'b0101, StExeAl = 4'b0110, StWbAl = 4'b0111, StHalt = 4'b1000
  } state_e;
`else
  typedef enum logic [2:0] {
    StIf = 3'b000, StId = 3'b001, StExeLs = 3'b010, StMem = 3'b011, StWbLd = 3'b100,
    StExeBr = 3'b101, StExeAl = 3'b110, StWbAl = 3'b111
  } state_e;
`endif

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       mem_err_q, mem_err_d;

  logic is_r, is_imm, is_alu, is_beq, is_bne, is_br, is_lw, is_sw, is_ls, is_j, is_jal, is_halt;
  logic tmo, mem_done;

  assign is_r   = (op == OpAdd) || (op == OpSub) || (op == OpSlt);
  assign is_imm = (op == OpAndi) || (op == OpOri);
  assign is_alu = is_r || is_imm;
  assign is_beq = (op == OpBeq);
  assign is_bne = (op == OpBne);
  assign is_br  = is_beq || is_bne;
  assign is_lw  = (op == OpLw);
  assign is_sw  = (op == OpSw);
  assign is_ls  = is_lw || is_sw;
  assign is_jal = (op == OpJal);
  assign is_j   = (op == OpJ) || is_jal;
`ifdef HALT_EN
  assign is_halt = (op == OpHalt);
`else
  assign is_halt = 1'b0;
`endif

  // mem_ready on the timeout cycle wins: the access completes without an error.
  assign tmo      = (wait_q == TmoLast);
  assign mem_done = mem_ready || tmo;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q   <= StIf;
      wait_q    <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = (state_q == StMem) ? wait_q + 8'd1 : 8'd0;
    mem_err_d = mem_err_q || ((state_q == StMem) && tmo && !mem_ready);
    unique case (state_q)
      StIf: state_d = StId;
      StId: begin
        if (is_alu)      state_d = StExeAl;
        else if (is_br)  state_d = StExeBr;
        else if (is_ls)  state_d = StExeLs;
`ifdef HALT_EN
        else if (is_halt) state_d = StHalt;
`endif
        else             state_d = StIf;
      end
      StExeAl: state_d = StWbAl;
      StWbAl:  state_d = StIf;
      StExeBr: state_d = StIf;
      StExeLs: state_d = StMem;
      StMem:   if (mem_done) state_d = is_lw ? StWbLd : StIf;
      StWbLd:  state_d = StIf;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    RegDst    = 2'b00;
    DBDataSrc = 1'b0;
    PCSrc     = 2'b00;
    ALUOp     = 3'b000;
    if (Reset) begin
      unique case (state_q)
        StIf: IRWre = 1'b1;
        StId: begin
          if (!(is_alu || is_br || is_ls || is_halt)) begin
            PCWre = 1'b1;
            PCSrc = is_j ? 2'b10 : 2'b00;
            if (is_jal) begin
              RegWre = 1'b1;
              RegDst = 2'b00;
            end
          end
        end
        StExeAl, StExeLs, StExeBr: begin
          ALUSrcB = is_imm || is_ls;
          ExtSel  = is_ls || is_br;
          if (op == OpSub || is_br) ALUOp = 3'b001;
          else if (op == OpAndi)    ALUOp = 3'b010;
          else if (op == OpOri)     ALUOp = 3'b011;
          else if (op == OpSlt)     ALUOp = 3'b100;
          else                      ALUOp = 3'b000;
          if (state_q == StExeBr) begin
            PCWre = 1'b1;
            PCSrc = ((is_beq && zero) || (is_bne && !zero)) ? 2'b01 : 2'b00;
          end
        end
        StWbAl: begin
          RegWre = 1'b1;
          PCWre  = 1'b1;
          RegDst = is_r ? 2'b10 : 2'b01;
        end
        StMem: begin
          mRD   = is_lw;
          mWR   = is_sw;
          PCWre = is_sw && mem_done;
        end
        StWbLd: begin
          RegWre    = 1'b1;
          PCWre     = 1'b1;
          RegDst    = 2'b01;
          DBDataSrc = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state   = state_q[2:0];
  assign mem_err = mem_err_q;
`ifdef HALT_EN
  assign halted  = (state_q == StHalt);
`else
  assign halted  = 1'b0;
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomised self-checking bench for multi_cycle_control; builds per-cycle expectations from
// an instruction-level model of the control sequence. Honours HALT_EN like the design.
module tb_multi_cycle_control;
  localparam int unsigned Tmo = 15;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] state, RegDst, PCSrc_pad;
  logic       PCWre, IRWre, RegWre, mRD, mWR, ALUSrcB, ExtSel, DBDataSrc, mem_err, halted;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;
  logic [1:0] RegDst2;

  multi_cycle_control #(.MEM_TMO(Tmo), .OPW(6)) dut (
    .CLK(CLK), .Reset(Reset), .op(op), .zero(zero), .mem_ready(mem_ready), .state(state),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .mRD(mRD), .mWR(mWR), .ALUSrcB(ALUSrcB),
    .ExtSel(ExtSel), .RegDst(RegDst2), .DBDataSrc(DBDataSrc), .PCSrc(PCSrc), .ALUOp(ALUOp),
    .mem_err(mem_err), .halted(halted)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        mr;
    logic [19:0] v;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        e;
  logic        err_m = 1'b0;
  int          nvec = 0;
  int          nbad = 0;
  logic [5:0]  cur_op = 6'd0;
  logic        cur_z = 1'b0;
  logic        cur_rst = 1'b0;
  logic [19:0] got;

  // Fields: state, {PCWre,IRWre,RegWre,mRD,mWR}, {ALUSrcB,ExtSel}, RegDst, DBDataSrc, PCSrc,
  // ALUOp, mem_err, halted.
  function automatic logic [19:0] mk(input logic [2:0] st, input logic [4:0] en,
                                     input logic [1:0] se, input logic [1:0] rdst,
                                     input logic dbs, input logic [1:0] pcs,
                                     input logic [2:0] aop, input logic err, input logic hlt);
    return {st, en, se, rdst, dbs, pcs, aop, err, hlt};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input logic mr);
    @(negedge CLK);
    Reset     = cur_rst;
    op        = cur_op;
    zero      = cur_z;
    mem_ready = mr;
    #1;
    got = {state, PCWre, IRWre, RegWre, mRD, mWR, ALUSrcB, ExtSel, RegDst2, DBDataSrc, PCSrc,
           ALUOp, mem_err, halted};
  endtask

  // Expected cycles of one instruction; w is the MEM cycle on which mem_ready rises
  // (outside 1..Tmo means it never rises before the timeout).
  task automatic model_instr(input logic [5:0] o, input logic z, input int w);
    logic [2:0] aop;
    logic [1:0] se;
    logic       rtype;
    int         cls;  // 0 nop, 1 alu, 2 branch, 3 ld/st, 4 jump, 5 halt
    bit         to;
    int         m;
    aop = 3'b000; se = 2'b00; rtype = 1'b0; cls = 0;
    case (o)
      6'b000000: begin cls = 1; rtype = 1; end
      6'b000001: begin cls = 1; rtype = 1; aop = 3'b001; end
      6'b100111: begin cls = 1; rtype = 1; aop = 3'b100; end
      6'b010000: begin cls = 1; aop = 3'b010; se = 2'b10; end
      6'b010010: begin cls = 1; aop = 3'b011; se = 2'b10; end
      6'b110000, 6'b110001: begin cls = 3; se = 2'b11; end
      6'b110100, 6'b110101: begin cls = 2; aop = 3'b001; se = 2'b01; end
      6'b111000, 6'b111010: cls = 4;
`ifdef HALT_EN
      6'b111111: cls = 5;
`endif
      default: cls = 0;
    endcase
    exp_q.push_back('{mr: rb(), v: mk(3'b000, 5'b01000, 2'b00, 2'b00, 0, 2'b00, 3'b000, err_m, 0)});
    case (cls)
      1: begin
        exp_q.push_back('{mr: rb(), v: mk(3'b001, 5'b0, 2'b00, 2'b00, 0, 2'b00, 3'b0, err_m, 0)});
        exp_q.push_back('{mr: rb(), v: mk(3'b110, 5'b0, se, 2'b00, 0, 2'b00, aop, err_m, 0)});
        exp_q.push_back('{mr: rb(), v: mk(3'b111, 5'b10100, 2'b00, rtype ? 2'b10 : 2'b01, 0,
                                          2'b00, 3'b0, err_m, 0)});
      end
      2: begin
        exp_q.push_back('{mr: rb(), v: mk(3'b001, 5'b0, 2'b00, 2'b00, 0, 2'b00, 3'b0, err_m, 0)});
        exp_q.push_back('{mr: rb(), v: mk(3'b101, 5'b10000, se, 2'b00, 0,
                                          ((o == 6'b110100) == z) ? 2'b01 : 2'b00, aop,
                                          err_m, 0)});
      end
      3: begin
        to = !(w >= 1 && w <= int'(Tmo));
        m  = to ? int'(Tmo) : w;
        exp_q.push_back('{mr: rb(), v: mk(3'b001, 5'b0, 2'b00, 2'b00, 0, 2'b00, 3'b0, err_m, 0)});
        exp_q.push_back('{mr: rb(), v: mk(3'b010, 5'b0, se, 2'b00, 0, 2'b00, aop, err_m, 0)});
        for (int k = 1; k <= m; k++)
          exp_q.push_back('{mr: (k == w), v: mk(3'b011, {(o == 6'b110000) && (k == m), 2'b00,
                                                 o == 6'b110001, o == 6'b110000}, 2'b00, 2'b00,
                                                 0, 2'b00, 3'b0, err_m, 0)});
        err_m = err_m | to;
        if (o == 6'b110001)
          exp_q.push_back('{mr: rb(), v: mk(3'b100, 5'b10100, 2'b00, 2'b01, 1, 2'b00, 3'b0,
                                            err_m, 0)});
      end
      4: exp_q.push_back('{mr: rb(), v: mk(3'b001, {2'b10, o == 6'b111010, 2'b00}, 2'b00,
                                           2'b00, 0, 2'b10, 3'b0, err_m, 0)});
      5: exp_q.push_back('{mr: rb(), v: mk(3'b001, 5'b0, 2'b00, 2'b00, 0, 2'b00, 3'b0, err_m, 0)});
      default: exp_q.push_back('{mr: rb(), v: mk(3'b001, 5'b10000, 2'b00, 2'b00, 0, 2'b00, 3'b0,
                                                 err_m, 0)});
    endcase
  endtask

  task automatic test_reset();
    cur_rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(rb());
      nvec++;
      if (got !== mk(3'b000, 5'b0, 2'b00, 2'b00, 0, 2'b00, 3'b0, 0, 0)) begin
        nbad++;
        $display("FAIL reset cyc%0d: got %b want %b", i, got,
                 mk(3'b000, 5'b0, 2'b00, 2'b00, 0, 2'b00, 3'b0, 0, 0));
      end
    end
    cur_rst = 1'b1;
    err_m   = 1'b0;
  endtask

  task automatic test_alu();
    logic [5:0] ops[5] = '{6'b000000, 6'b000001, 6'b010000, 6'b010010, 6'b100111};
    foreach (ops[i]) begin
      cur_op = ops[i];
      cur_z  = rb();
      model_instr(ops[i], cur_z, 0);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        step(e.mr);
        nvec++;
        if (got !== e.v) begin
          nbad++;
          $display("FAIL alu op=%b: got %b want %b", ops[i], got, e.v);
        end
      end
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops[4] = '{6'b110100, 6'b110100, 6'b110101, 6'b110101};
    logic       zs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    foreach (ops[i]) begin
      cur_op = ops[i];
      cur_z  = zs[i];
      model_instr(ops[i], zs[i], 0);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        step(e.mr);
        nvec++;
        if (got !== e.v) begin
          nbad++;
          $display("FAIL branch op=%b z=%b: got %b want %b", ops[i], zs[i], got, e.v);
        end
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [5:0] ops[4] = '{6'b110001, 6'b110000, 6'b110001, 6'b110000};
    int         ws[4]  = '{4, 1, 15, 1000};  // last: never ready, forces the timeout
    foreach (ops[i]) begin
      cur_op = ops[i];
      cur_z  = rb();
      model_instr(ops[i], cur_z, ws[i]);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        step(e.mr);
        nvec++;
        if (got !== e.v) begin
          nbad++;
          $display("FAIL mem op=%b w=%0d: got %b want %b", ops[i], ws[i], got, e.v);
        end
      end
    end
    // mem_err must stay set through later instructions
    cur_op = 6'b000000;
    model_instr(cur_op, 1'b0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step(e.mr);
      nvec++;
      if (got !== e.v) begin
        nbad++;
        $display("FAIL sticky_err: got %b want %b", got, e.v);
      end
    end
  endtask

  task automatic test_reset_mid();
    cur_op = 6'b000000;
    model_instr(cur_op, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      step(e.mr);
      nvec++;
      if (got !== e.v) begin
        nbad++;
        $display("FAIL rst_mid pre%0d: got %b want %b", i, got, e.v);
      end
    end
    exp_q.delete();
    cur_rst = 1'b0;
    step(1'b0);
    nvec++;
    if (got !== mk(3'b111, 5'b0, 2'b00, 2'b00, 0, 2'b00, 3'b0, err_m, 0)) begin
      nbad++;
      $display("FAIL rst_mid gated: got %b want %b", got,
               mk(3'b111, 5'b0, 2'b00, 2'b00, 0, 2'b00, 3'b0, err_m, 0));
    end
    step(1'b0);
    nvec++;
    if (got !== mk(3'b000, 5'b0, 2'b00, 2'b00, 0, 2'b00, 3'b0, 0, 0)) begin
      nbad++;
      $display("FAIL rst_mid cleared: got %b want %b", got,
               mk(3'b000, 5'b0, 2'b00, 2'b00, 0, 2'b00, 3'b0, 0, 0));
    end
    cur_rst = 1'b1;
    err_m   = 1'b0;
  endtask

  task automatic test_halt();
    cur_op = 6'b111111;
    model_instr(cur_op, 1'b0, 0);
`ifdef HALT_EN
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{mr: rb(), v: mk(3'b000, 5'b0, 2'b00, 2'b00, 0, 2'b00, 3'b0, err_m, 1)});
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step(e.mr);
      nvec++;
      if (got !== e.v) begin
        nbad++;
        $display("FAIL halt: got %b want %b", got, e.v);
      end
    end
`ifdef HALT_EN
    cur_rst = 1'b0;
    step(1'b0);
    step(1'b0);
    nvec++;
    if (got !== mk(3'b000, 5'b0, 2'b00, 2'b00, 0, 2'b00, 3'b0, 0, 0)) begin
      nbad++;
      $display("FAIL halt_reset: got %b want %b", got,
               mk(3'b000, 5'b0, 2'b00, 2'b00, 0, 2'b00, 3'b0, 0, 0));
    end
    cur_rst = 1'b1;
    err_m   = 1'b0;
`endif
  endtask

  task automatic test_random();
    logic [5:0] pool[13] = '{6'b000000, 6'b000001, 6'b010000, 6'b010010, 6'b100111, 6'b110000,
                             6'b110001, 6'b110100, 6'b110101, 6'b111000, 6'b111010, 6'b111111,
                             6'b001100};
    int w;
    for (int n = 0; n < 60; n++) begin
      cur_op = (n % 5 == 4) ? 6'($urandom) : pool[$urandom_range(0, 12)];
`ifdef HALT_EN
      if (cur_op == 6'b111111) cur_op = 6'b000000;
`endif
      cur_z = rb();
      w     = $urandom_range(1, 20);
      model_instr(cur_op, cur_z, w);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        step(e.mr);
        nvec++;
        if (got !== e.v) begin
          nbad++;
          $display("FAIL random op=%b z=%b w=%0d: got %b want %b", cur_op, cur_z, w, got, e.v);
        end
      end
    end
    // trailing NOP also confirms the last random instruction returned to IF on time
    cur_op = 6'b001100;
    model_instr(cur_op, 1'b0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step(e.mr);
      nvec++;
      if (got !== e.v) begin
        nbad++;
        $display("FAIL tail: got %b want %b", got, e.v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_mem_wait();
    test_reset_mid();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
